// File: rtl/bus_resp_sram_if.sv
// rtl/bus_resp_sram_if.sv - CPU data-port request/response bundle for bus_resp_sram
// Optional err signal present only when BUS_RESP_ERR_EN is defined.
interface bus_resp_sram_if;
    logic        cpu_ce;
    logic        cpu_we;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic [31:0] rd_data_to_cpu;
    logic        stall_req;
`ifdef BUS_RESP_ERR_EN
    logic        err;
`endif

    modport master (
        output cpu_ce, cpu_we, cpu_sel, cpu_addr, cpu_wr_data,
`ifdef BUS_RESP_ERR_EN
        input  err,
`endif
        input  rd_data_to_cpu, stall_req
    );

    modport slave (
        input  cpu_ce, cpu_we, cpu_sel, cpu_addr, cpu_wr_data,
`ifdef BUS_RESP_ERR_EN
        output err,
`endif
        output rd_data_to_cpu, stall_req
    );
endinterface

// File: rtl/bus_resp_sram.sv
// rtl/bus_resp_sram.sv - wait-state SRAM responder with stall_req handshake
// Optional address-error reporting enabled by BUS_RESP_ERR_EN.
module bus_resp_sram #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    bus_resp_sram_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t              r_state;
    logic [3:0]          r_count;
    logic [31:0]         r_rd_data;
    logic [31:0]         r_mem [0:(1 << ADDR_W) - 1];

    logic [ADDR_W-1:0]   w_idx;
    logic                w_access;
    logic                w_wr_en;
    logic                w_addr_err;
    logic                w_unused;

    assign w_idx    = bus.cpu_addr[ADDR_W+1:2];
    assign w_unused = &{1'b0, bus.cpu_addr[1:0], bus.cpu_addr[31:ADDR_W+2]};

`ifdef BUS_RESP_ERR_EN
    assign w_addr_err = |bus.cpu_addr[31:ADDR_W+2];
`else
    assign w_addr_err = 1'b0;
`endif

    // The access edge: immediate acceptance with no wait states, or the last BUSY cycle.
    assign w_access = ((r_state == IDLE) && bus.cpu_ce && (WAIT_CYCLES == 0)) ||
                      ((r_state == BUSY) && (r_count == 4'd1));
    assign w_wr_en  = w_access && bus.cpu_we && !w_addr_err && !rst;

    // Reset gates stall_req so it drops as soon as rst rises.
    assign bus.stall_req      = !rst && (((r_state == IDLE) && bus.cpu_ce) || (r_state == BUSY));
    assign bus.rd_data_to_cpu = r_rd_data;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int n = 0; n < 4; n++) begin
                if (bus.cpu_sel[n]) begin
                    r_mem[w_idx][8*n +: 8] <= bus.cpu_wr_data[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= 4'd0;
            r_rd_data <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cpu_ce) begin
                        if (WAIT_CYCLES == 0) begin
                            r_state <= DONE;
                        end else begin
                            r_count <= WAIT_LOAD;
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!stall_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_access && !bus.cpu_we) begin
                r_rd_data <= w_addr_err ? 32'hDEADBEEF : r_mem[w_idx];
            end
        end
    end

`ifdef BUS_RESP_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_access) begin
            r_err <= w_addr_err;
        end else if ((r_state == DONE) && !stall_i) begin
            r_err <= 1'b0;
        end
    end

    assign bus.err = r_err;
`endif
endmodule

// File: doc/bus_resp_sram.md
Name: bus_resp_sram

Overview:
- Wait-state memory responder for one CPU port of the system bus (the ce/we/sel/addr/wr_data request side).
- Each access is answered after a configurable latency.
- Holds stall_req high until the access completes, then returns read data.
- Sits behind bus_top as the data-memory responder; the stall controller consumes its stall_req.

Parameters:
- ADDR_W, 10, word-address width; memory depth = 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 2, extra wait cycles per access, legal range 0..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- stall_i  in  1  global pipeline stall; high means the requester will not advance this cycle.
- cpu_ce  in  1  request valid.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_sel  in  4  byte enables, active-high; bit n covers byte lane n.
- cpu_addr  in  32  byte address.
- cpu_wr_data  in  32  write data.
- rd_data_to_cpu  out  32  read data.
- stall_req  out  1  access pending; the requester must hold its request stable while this is high.
- err  out  1  address error, present only with the optional feature.

Behaviour:
- Reset (async):
  - state = IDLE, counter = 0.
  - rd_data_to_cpu = 0, stall_req = 0, err = 0.
  - Memory contents undefined; reset does not clear the array.
- States: IDLE, BUSY, DONE.
- stall_req is combinational:
  - 1 in IDLE when cpu_ce = 1.
  - 1 in BUSY.
  - 0 otherwise.
- IDLE:
  - cpu_ce = 0: stay in IDLE.
  - cpu_ce = 1 and WAIT_CYCLES > 0: load counter with WAIT_CYCLES, go to BUSY.
  - cpu_ce = 1 and WAIT_CYCLES = 0: perform the access at this clock edge, go to DONE.
- BUSY:
  - Decrement counter each cycle.
  - On the edge where counter = 1, perform the access and go to DONE.
- Access, using the inputs sampled at that edge:
  - Word index = cpu_addr[ADDR_W+1:2]; cpu_addr[1:0] ignored.
  - Write: each byte lane with cpu_sel[n] = 1 is updated; lanes with sel = 0 are unchanged; rd_data_to_cpu unchanged.
  - Write with cpu_sel = 0: completes normally, no bytes change.
  - Read: rd_data_to_cpu <= full 32-bit word regardless of cpu_sel.
- DONE:
  - stall_req = 0; rd_data_to_cpu stable.
  - stall_i = 1: stay in DONE. This prevents the same request being serviced twice while another unit stalls the pipeline.
  - stall_i = 0: go to IDLE.
- Latency:
  - stall_req is high for exactly WAIT_CYCLES+1 cycles per access.
  - Read data is valid in the first DONE cycle.
- rd_data_to_cpu holds its last read value in all other states.
- cpu_ce dropping while in BUSY: the access still completes using the inputs present at the access edge. This is a requester protocol violation; the bench flags it.
- Address bits above ADDR_W+1 are ignored, so addresses alias and wrap modulo the depth.
- rst asserted mid-access: return immediately to IDLE, no write occurs, stall_req drops.
- Back-to-back accesses: minimum gap of one IDLE cycle between DONE and the next acceptance.

Optional Feature:
- Macro BUS_RESP_ERR_EN.
- Defined:
  - err port exists.
  - Any nonzero cpu_addr[31:ADDR_W+2] at the access edge makes that access an error.
  - Error write: suppressed, no bytes change.
  - Error read: rd_data_to_cpu <= 32'hDEADBEEF.
  - err = 1 for all DONE cycles of that access, 0 otherwise; reset 0.
  - Latency and state sequence are unchanged.
- Undefined: no err port; upper address bits alias as described above.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - Write addr 0x10, data 0xA5A5_1234, sel 4'b1111: stall_req high 3 cycles.
  - Then read 0x10: rd_data_to_cpu = 0xA5A5_1234 in the first DONE cycle.
- Byte-lane write:
  - Preload 0x11223344 at 0x20, write 0xAABBCCDD with sel 4'b0101.
  - Read 0x20 returns 0x11BB33DD.
- WAIT_CYCLES=0 build:
  - Read accepted in IDLE: stall_req high exactly 1 cycle, data valid the next cycle.
- Global stall in DONE:
  - Hold stall_i=1 for 4 cycles after a write of 0x1 to 0x30.
  - FSM stays in DONE with stall_req = 0; write happens once.
  - Re-reading 0x30 returns 0x1.
- Reset mid-BUSY:
  - Assert rst in the second wait cycle of a write of 0xFFFF_FFFF to 0x40 (preloaded 0x0).
  - stall_req drops asynchronously; a later read of 0x40 returns 0x0.
- Aliasing, and error with BUS_RESP_ERR_EN:
  - Without the macro: read of addr 0x1000_0010 returns the word at 0x10.
  - With the macro: same read returns 0xDEADBEEF with err = 1 in DONE; memory unchanged.
